// File: rtl/sprite_animator.sv
// Pipelined sprite renderer with multi-frame animation, horizontal mirroring and
// power-of-two upscaling; reads an external ROM and returns a palette index two clocks later.
module sprite_animator #(
    parameter int SPR_W      = 140,
    parameter int SPR_H      = 240,
    parameter int FRAMES     = 8,
    parameter int IDX_W      = 5,
    parameter int ADDR_W     = 19,
    parameter int TICK_W     = 4,
    parameter int TRANSP_IDX = 0
) (
    input  logic                      vga_clk,
    input  logic                      reset,
    input  logic [9:0]                DrawX,
    input  logic [9:0]                DrawY,
    input  logic [9:0]                SpriteX,
    input  logic [9:0]                SpriteY,
    input  logic                      blank,
    input  logic                      frame_tick,
    input  logic                      start,
    input  logic                      stop,
    input  logic [$clog2(FRAMES)-1:0] anim_base,
    input  logic [$clog2(FRAMES):0]   anim_len,
    input  logic                      loop,
    input  logic [TICK_W-1:0]         hold_ticks,
    input  logic                      flip,
    input  logic [1:0]                scale_sh,
    output logic [ADDR_W-1:0]         rom_addr,
    input  logic [IDX_W-1:0]          rom_q,
    output logic [IDX_W-1:0]          pix_index,
    output logic                      sprite_on,
    output logic [$clog2(FRAMES)-1:0] cur_frame,
    output logic                      busy,
    output logic                      anim_done
);
    localparam int FW    = $clog2(FRAMES);
    localparam int LEN_W = FW + 1;
    localparam int SUM_W = LEN_W + 1;
    localparam int HW    = 11;
    localparam logic [ADDR_W-1:0] FRAME_SZ = ADDR_W'(SPR_W * SPR_H);

    typedef enum logic [1:0] {IDLE, PLAY, DONE} state_e;

    state_e              state_q, state_d;
    logic [LEN_W-1:0]    step_q, step_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [FW-1:0]       base_q, base_d;
    logic                loop_q, loop_d;
    logic [TICK_W-1:0]   hold_q, hold_d;
    logic [TICK_W-1:0]   tick_q, tick_d;
    logic                done_d;
    logic [SUM_W-1:0]    frameSum;
    logic [FW-1:0]       frame_d, cur_frame_q;
    logic                busy_q, anim_done_q;

    logic [HW-1:0]       dx, dy, spanW, spanH, colRaw, col, row;
    logic                hit;
    logic [ADDR_W-1:0]   hitAddr, rom_addr_q;
    logic                v1_q, sprite_on_q;
    logic [IDX_W-1:0]    pix_index_q;
    logic                opaque;

    // Stage 0: widened so that sprites near the right/bottom edge never wrap the offset.
    always_comb begin
        dx      = HW'(DrawX) - HW'(SpriteX);
        dy      = HW'(DrawY) - HW'(SpriteY);
        spanW   = HW'(SPR_W) << scale_sh;
        spanH   = HW'(SPR_H) << scale_sh;
        hit     = (DrawX >= SpriteX) && (dx < spanW) && (DrawY >= SpriteY) && (dy < spanH);
        colRaw  = dx >> scale_sh;
        col     = flip ? (HW'(SPR_W - 1) - colRaw) : colRaw;
        row     = dy >> scale_sh;
        hitAddr = ADDR_W'(cur_frame_q) * FRAME_SZ + ADDR_W'(row) * ADDR_W'(SPR_W) + ADDR_W'(col);
    end

    // Start overrides both stop and frame_tick; a finished one-shot holds its last step.
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        len_d   = len_q;
        base_d  = base_q;
        loop_d  = loop_q;
        hold_d  = hold_q;
        tick_d  = tick_q;
        done_d  = 1'b0;
        if (start) begin
            base_d  = anim_base;
            len_d   = (anim_len == '0) ? LEN_W'(1) : anim_len;
            loop_d  = loop;
            hold_d  = hold_ticks;
            step_d  = '0;
            tick_d  = '0;
            state_d = PLAY;
        end else if (stop && (state_q != IDLE)) begin
            state_d = IDLE;
        end else if ((state_q == PLAY) && frame_tick) begin
            if (tick_q == hold_q) begin
                tick_d = '0;
                if (step_q < (len_q - LEN_W'(1))) begin
                    step_d = step_q + LEN_W'(1);
                end else if (loop_q) begin
                    step_d = '0;
                end else begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end
            end else begin
                tick_d = tick_q + TICK_W'(1);
            end
        end
        frameSum = SUM_W'(base_d) + SUM_W'(step_d);
        frame_d  = (frameSum > SUM_W'(FRAMES - 1)) ? FW'(FRAMES - 1) : FW'(frameSum);
    end

    assign opaque = v1_q && (rom_q != IDX_W'(TRANSP_IDX));

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            state_q     <= IDLE;
            step_q      <= '0;
            len_q       <= LEN_W'(1);
            base_q      <= '0;
            loop_q      <= 1'b0;
            hold_q      <= '0;
            tick_q      <= '0;
            cur_frame_q <= '0;
            busy_q      <= 1'b0;
            anim_done_q <= 1'b0;
            rom_addr_q  <= '0;
            v1_q        <= 1'b0;
            sprite_on_q <= 1'b0;
            pix_index_q <= '0;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            len_q       <= len_d;
            base_q      <= base_d;
            loop_q      <= loop_d;
            hold_q      <= hold_d;
            tick_q      <= tick_d;
            cur_frame_q <= frame_d;
            busy_q      <= (state_d == PLAY);
            anim_done_q <= done_d;
            rom_addr_q  <= hit ? hitAddr : '0;
            v1_q        <= hit && blank;
            sprite_on_q <= opaque;
            pix_index_q <= opaque ? rom_q : '0;
        end
    end

    assign rom_addr  = rom_addr_q;
    assign sprite_on = sprite_on_q;
    assign pix_index = pix_index_q;
    assign cur_frame = cur_frame_q;
    assign busy      = busy_q;
    assign anim_done = anim_done_q;
endmodule

// File: tb/tb_sprite_animator.sv
// Randomised scoreboard bench for sprite_animator: a behavioural model predicts every
// registered output per clock and a monitor process compares them as the DUT produces them.
module tb_sprite_animator;
    localparam int SPR_W      = 140;
    localparam int SPR_H      = 240;
    localparam int FRAMES     = 8;
    localparam int IDX_W      = 5;
    localparam int ADDR_W     = 19;
    localparam int TICK_W     = 4;
    localparam int TRANSP_IDX = 0;

    logic              vga_clk = 1'b0;
    logic              reset = 1'b1;
    logic [9:0]        DrawX = '0, DrawY = '0, SpriteX = '0, SpriteY = '0;
    logic              blank = 1'b0, frame_tick = 1'b0, start = 1'b0, stop = 1'b0;
    logic [2:0]        anim_base = '0;
    logic [3:0]        anim_len = '0;
    logic              loop = 1'b0, flip = 1'b0;
    logic [TICK_W-1:0] hold_ticks = '0;
    logic [1:0]        scale_sh = '0;
    logic [ADDR_W-1:0] rom_addr;
    logic [IDX_W-1:0]  rom_q, pix_index;
    logic              sprite_on, busy, anim_done;
    logic [2:0]        cur_frame;

    sprite_animator #(
        .SPR_W(SPR_W), .SPR_H(SPR_H), .FRAMES(FRAMES), .IDX_W(IDX_W),
        .ADDR_W(ADDR_W), .TICK_W(TICK_W), .TRANSP_IDX(TRANSP_IDX)
    ) dut (
        .vga_clk(vga_clk), .reset(reset), .DrawX(DrawX), .DrawY(DrawY),
        .SpriteX(SpriteX), .SpriteY(SpriteY), .blank(blank), .frame_tick(frame_tick),
        .start(start), .stop(stop), .anim_base(anim_base), .anim_len(anim_len),
        .loop(loop), .hold_ticks(hold_ticks), .flip(flip), .scale_sh(scale_sh),
        .rom_addr(rom_addr), .rom_q(rom_q), .pix_index(pix_index), .sprite_on(sprite_on),
        .cur_frame(cur_frame), .busy(busy), .anim_done(anim_done)
    );

    always #5 vga_clk = ~vga_clk;

    // ROM contents: every fifth word is transparent, the rest a nonzero pattern.
    function automatic logic [IDX_W-1:0] romFn(input int a);
        if (a % 5 == 2) return IDX_W'(TRANSP_IDX);
        return IDX_W'((a * 7 + 6) % 31 + 1);
    endfunction

    assign rom_q = romFn(int'(rom_addr));

    typedef struct { int due; int addr; }            addrExp_t;
    typedef struct { int due; int on; int pix; }     pixExp_t;
    typedef struct { int due; int frame; int busy; int done; } ctlExp_t;

    addrExp_t addrQ[$];
    pixExp_t  pixQ[$];
    ctlExp_t  ctlQ[$];
    addrExp_t ae;
    pixExp_t  pe, pend;
    ctlExp_t  ce;
    bit       pendValid = 1'b0;

    int edgeCnt = 0;
    int checks = 0;
    int errors = 0;

    always @(posedge vga_clk) edgeCnt <= edgeCnt + 1;

    // Shadow stimulus; pulse fields are cleared after each applied cycle.
    int nReset = 1, nStart = 0, nStop = 0, nTick = 0;
    int nBase = 0, nLen = 0, nLoop = 0, nHold = 0;
    int nDX = 0, nDY = 0, nSX = 0, nSY = 0, nBlank = 0, nFlip = 0, nSh = 0;

    // Animation model: elapsed ticks since start, divided into steps of (hold+1) ticks.
    int mMode = 0, mBase = 0, mLen = 1, mLoop = 0, mHold = 0, mT = 0, mDone = 0;

    function automatic int modelFrame();
        int q, s;
        q = mT / (mHold + 1);
        if (mLoop != 0) s = q % mLen;
        else s = (q < mLen - 1) ? q : mLen - 1;
        return (mBase + s > FRAMES - 1) ? FRAMES - 1 : mBase + s;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus();
        int k, dx, dy, col, row, addr;
        bit hit;
        @(posedge vga_clk);
        #1;
        k = edgeCnt;
        reset      = (nReset != 0);
        start      = (nStart != 0);
        stop       = (nStop != 0);
        frame_tick = (nTick != 0);
        anim_base  = 3'(nBase);
        anim_len   = 4'(nLen);
        loop       = (nLoop != 0);
        hold_ticks = TICK_W'(nHold);
        DrawX      = 10'(nDX);
        DrawY      = 10'(nDY);
        SpriteX    = 10'(nSX);
        SpriteY    = 10'(nSY);
        blank      = (nBlank != 0);
        flip       = (nFlip != 0);
        scale_sh   = 2'(nSh);

        if (pendValid) begin
            if (nReset != 0) begin
                pend.on  = 0;
                pend.pix = 0;
            end
            pixQ.push_back(pend);
        end
        dx  = nDX - nSX;
        dy  = nDY - nSY;
        hit = (dx >= 0) && (dx < (SPR_W << nSh)) && (dy >= 0) && (dy < (SPR_H << nSh));
        col = dx / (1 << nSh);
        if (nFlip != 0) col = SPR_W - 1 - col;
        row  = dy / (1 << nSh);
        addr = (hit && nReset == 0) ? modelFrame() * SPR_W * SPR_H + row * SPR_W + col : 0;
        addrQ.push_back('{k + 1, addr});
        pend.due  = k + 2;
        pend.on   = (nReset == 0 && hit && nBlank != 0 && romFn(addr) != IDX_W'(TRANSP_IDX)) ? 1 : 0;
        pend.pix  = (pend.on != 0) ? int'(romFn(addr)) : 0;
        pendValid = 1'b1;

        mDone = 0;
        if (nReset != 0) begin
            mMode = 0; mBase = 0; mLen = 1; mLoop = 0; mHold = 0; mT = 0;
        end else if (nStart != 0) begin
            mMode = 1; mBase = nBase; mLen = (nLen == 0) ? 1 : nLen;
            mLoop = nLoop; mHold = nHold; mT = 0;
        end else if (nStop != 0 && mMode != 0) begin
            mMode = 0;
        end else if (mMode == 1 && nTick != 0) begin
            mT++;
            if (mLoop == 0 && mT == mLen * (mHold + 1)) begin
                mMode = 2;
                mDone = 1;
            end
        end
        ctlQ.push_back('{k + 1, modelFrame(), (mMode == 1) ? 1 : 0, mDone});

        nReset = 0; nStart = 0; nStop = 0; nTick = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus();
    endtask

    always @(negedge vga_clk) begin
        while (addrQ.size() > 0 && addrQ[0].due <= edgeCnt) begin
            ae = addrQ.pop_front();
            if (ae.due != edgeCnt) checkOutput("addrLate", ae.due, edgeCnt);
            else checkOutput("rom_addr", int'(rom_addr), ae.addr);
        end
        while (pixQ.size() > 0 && pixQ[0].due <= edgeCnt) begin
            pe = pixQ.pop_front();
            if (pe.due != edgeCnt) checkOutput("pixLate", pe.due, edgeCnt);
            else begin
                checkOutput("sprite_on", int'(sprite_on), pe.on);
                checkOutput("pix_index", int'(pix_index), pe.pix);
            end
        end
        while (ctlQ.size() > 0 && ctlQ[0].due <= edgeCnt) begin
            ce = ctlQ.pop_front();
            if (ce.due != edgeCnt) checkOutput("ctlLate", ce.due, edgeCnt);
            else begin
                checkOutput("cur_frame", int'(cur_frame), ce.frame);
                checkOutput("busy", int'(busy), ce.busy);
                checkOutput("anim_done", int'(anim_done), ce.done);
            end
        end
    end

    int loopExp[8] = '{2, 2, 3, 3, 4, 4, 2, 2};
    int span;

    initial begin
        nReset = 1;
        applyStimulus();
        applyStimulus();
        checkOutput("rst_rom_addr", int'(rom_addr), 0);
        checkOutput("rst_sprite_on", int'(sprite_on), 0);
        checkOutput("rst_pix_index", int'(pix_index), 0);
        checkOutput("rst_cur_frame", int'(cur_frame), 0);
        checkOutput("rst_busy", int'(busy), 0);
        checkOutput("rst_anim_done", int'(anim_done), 0);

        // Static draw at the sprite origin, then just past the right edge.
        nSX = 100; nSY = 50; nDX = 100; nDY = 50; nBlank = 1; nFlip = 0; nSh = 0;
        applyStimulus();
        applyStimulus();
        checkOutput("static_addr", int'(rom_addr), 0);
        applyStimulus();
        checkOutput("static_on", int'(sprite_on), 1);
        checkOutput("static_pix", int'(pix_index), 7);
        nDX = 240;
        idle(3);
        checkOutput("right_edge_on", int'(sprite_on), 0);

        // Transparent ROM word, then an opaque word outside active video.
        nDX = 102;
        idle(3);
        checkOutput("transp_on", int'(sprite_on), 0);
        checkOutput("transp_pix", int'(pix_index), 0);
        nDX = 100; nBlank = 0;
        idle(3);
        checkOutput("blank_on", int'(sprite_on), 0);

        nBlank = 1; nFlip = 1; nSh = 1; nDX = 103; nDY = 55;
        applyStimulus();
        applyStimulus();
        checkOutput("flip_scale_addr", int'(rom_addr), 418);
        nFlip = 0; nSh = 0;

        nStart = 1; nBase = 2; nLen = 3; nLoop = 1; nHold = 1;
        applyStimulus();
        applyStimulus();
        checkOutput("loop_frame0", int'(cur_frame), loopExp[0]);
        checkOutput("loop_busy", int'(busy), 1);
        for (int i = 1; i < 8; i++) begin
            nTick = 1;
            applyStimulus();
            applyStimulus();
            checkOutput("loop_frame", int'(cur_frame), loopExp[i]);
            checkOutput("loop_busy", int'(busy), 1);
        end

        nStart = 1; nBase = 6; nLen = 3; nLoop = 0; nHold = 0;
        applyStimulus();
        applyStimulus();
        checkOutput("oneshot_frame0", int'(cur_frame), 6);
        for (int i = 0; i < 2; i++) begin
            nTick = 1;
            applyStimulus();
            applyStimulus();
            checkOutput("oneshot_frame", int'(cur_frame), 7);
        end
        nTick = 1;
        applyStimulus();
        applyStimulus();
        checkOutput("oneshot_done", int'(anim_done), 1);
        checkOutput("oneshot_busy", int'(busy), 0);
        checkOutput("oneshot_held", int'(cur_frame), 7);
        applyStimulus();
        checkOutput("oneshot_pulse", int'(anim_done), 0);
        nStart = 1; nStop = 1;
        applyStimulus();
        applyStimulus();
        checkOutput("start_wins_busy", int'(busy), 1);
        checkOutput("start_wins_frame", int'(cur_frame), 6);
        nStop = 1;
        applyStimulus();
        applyStimulus();
        checkOutput("stop_busy", int'(busy), 0);
        checkOutput("stop_frame", int'(cur_frame), 6);

        // Reset while playing with a full pixel pipeline.
        nStart = 1; nBase = 1; nLen = 4; nLoop = 0; nHold = 0;
        nDX = 100; nDY = 50; nBlank = 1;
        applyStimulus();
        nTick = 1;
        applyStimulus();
        nTick = 1;
        applyStimulus();
        idle(2);
        checkOutput("pre_reset_frame", int'(cur_frame), 3);
        checkOutput("pre_reset_on", int'(sprite_on), 1);
        nReset = 1;
        applyStimulus();
        applyStimulus();
        checkOutput("reset_frame", int'(cur_frame), 0);
        checkOutput("reset_busy", int'(busy), 0);
        checkOutput("reset_on0", int'(sprite_on), 0);
        applyStimulus();
        checkOutput("reset_on1", int'(sprite_on), 0);

        for (int c = 0; c < 3000; c++) begin
            if (c % 64 == 0) begin
                nSX = int'($urandom_range(0, 400));
                nSY = int'($urandom_range(0, 300));
                nSh = int'($urandom_range(0, 3));
            end
            span = (SPR_W << nSh) + 8;
            nDX = nSX - 4 + int'($urandom_range(0, span));
            span = (SPR_H << nSh) + 8;
            nDY = nSY - 4 + int'($urandom_range(0, span));
            if (nDX < 0) nDX = 0;
            if (nDX > 1023) nDX = 1023;
            if (nDY < 0) nDY = 0;
            if (nDY > 1023) nDY = 1023;
            nFlip  = int'($urandom_range(0, 1));
            nBlank = ($urandom_range(0, 7) != 0) ? 1 : 0;
            nTick  = ($urandom_range(0, 3) == 0) ? 1 : 0;
            nStart = ($urandom_range(0, 39) == 0) ? 1 : 0;
            nStop  = ($urandom_range(0, 49) == 0) ? 1 : 0;
            nReset = ($urandom_range(0, 299) == 0) ? 1 : 0;
            nBase  = int'($urandom_range(0, 7));
            nLen   = int'($urandom_range(0, 15));
            nLoop  = int'($urandom_range(0, 1));
            nHold  = int'($urandom_range(0, 3));
            applyStimulus();
        end
        nTick = 0; nStart = 0; nStop = 0; nReset = 0;
        idle(4);
        @(negedge vga_clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sprite_animator.md
Name: sprite_animator

Overview:
- Parametrised, pipelined sprite renderer for the VGA path.
- Generalises the single-image sprite block with:
  - multi-frame animation sequencing, advanced on frame_tick (start of vertical blank)
  - horizontal flip
  - power-of-two upscaling
  - a parametrised transparent palette index
- Drives an external synchronous sprite ROM and returns a palette index plus a hit flag to the colour mapper, with a fixed 2-cycle latency.

Parameters:
- SPR_W, 140, sprite width in ROM pixels
- SPR_H, 240, sprite height in ROM pixels
- FRAMES, 8, number of frames stored back-to-back in the ROM
- IDX_W, 5, palette index width
- ADDR_W, 19, ROM address width; must be >= clog2(SPR_W*SPR_H*FRAMES)
- TICK_W, 4, width of the frame-hold counter
- TRANSP_IDX, 0, palette index treated as transparent

Ports:
- vga_clk  in  1  pixel clock
- reset  in  1  synchronous, active-high reset
- DrawX  in  10  current pixel column
- DrawY  in  10  current pixel row
- SpriteX  in  10  sprite top-left column
- SpriteY  in  10  sprite top-left row
- blank  in  1  1 = active video
- frame_tick  in  1  one-cycle pulse per video frame
- start  in  1  pulse: begin an animation
- stop  in  1  pulse: freeze on the current frame
- anim_base  in  clog2(FRAMES)  first frame of the sequence; sampled on start
- anim_len  in  clog2(FRAMES)+1  sequence length; sampled on start
- loop  in  1  1 = wrap, 0 = one-shot; sampled on start
- hold_ticks  in  TICK_W  frame_ticks per animation step, minus 1; sampled on start
- flip  in  1  horizontal mirror; sampled every pixel
- scale_sh  in  2  upscale shift, 0..3 (1x..8x)
- rom_addr  out  ADDR_W  ROM read address; registered
- rom_q  in  IDX_W  ROM data, valid 1 cycle after rom_addr
- pix_index  out  IDX_W  palette index of the sprite pixel
- sprite_on  out  1  opaque sprite pixel present
- cur_frame  out  clog2(FRAMES)  frame currently displayed
- busy  out  1  state == PLAY
- anim_done  out  1  one-cycle pulse at the end of a one-shot sequence

Behaviour:
- Reset (synchronous, vga_clk): state=IDLE, step=0, base=0, tick_cnt=0.
  - All outputs 0: rom_addr, pix_index, sprite_on, cur_frame, busy, anim_done.
  - Both pipeline valid bits cleared.
- Hit test (stage 0, combinational, computed in 11-bit arithmetic so nothing wraps):
  - dx = DrawX - SpriteX, dy = DrawY - SpriteY.
  - hit = DrawX >= SpriteX, dx < (SPR_W << scale_sh), DrawY >= SpriteY, dy < (SPR_H << scale_sh).
  - col = dx >> scale_sh; if flip, col = SPR_W-1-col.
  - row = dy >> scale_sh.
  - addr = cur_frame*SPR_W*SPR_H + row*SPR_W + col.
- Stage 1 (register):
  - rom_addr <= hit ? addr : 0.
  - v1 <= hit & blank.
- Stage 2 (register):
  - sprite_on <= v1 & (rom_q != TRANSP_IDX).
  - pix_index <= that same condition ? rom_q : 0.
- Latency: DrawX/DrawY/blank sampled at edge N produce sprite_on/pix_index at edge N+2. The caller delays its own DrawX-dependent signals by 2.
- Animation FSM, states IDLE, PLAY, DONE:
  - start, from any state: latch base, len, loop, hold; step=0, tick_cnt=0 → PLAY. If anim_len=0, use len=1.
  - PLAY, on frame_tick:
    - if tick_cnt == hold: tick_cnt=0, then advance.
    - otherwise tick_cnt++.
  - Advance:
    - step < len-1: step++.
    - else, loop=1: step=0.
    - else, loop=0: go to DONE and pulse anim_done for 1 cycle; step is held.
  - stop, in PLAY or DONE: → IDLE, step held.
  - start and stop in the same cycle: start wins.
  - start coincident with frame_tick: start wins; no advance that cycle.
  - frame_tick is ignored in IDLE and DONE.
- cur_frame = base + step, saturated at FRAMES-1.
  - Registered; it changes only on frame_tick or on start.
  - Frame changes mid-line are permitted only when start is pulsed mid-frame; this is the caller's responsibility.
- busy = (state == PLAY), registered.
- Reset asserted mid-line or mid-animation: all state clears on that edge; the pipeline outputs 0 for the next 2 cycles.

Test Plan:
- Static draw: reset, SpriteX=100, SpriteY=50, frame 0, scale_sh=0, flip=0; DrawX=100, DrawY=50, blank=1 → rom_addr=0 at N+1; rom_q=7 → sprite_on=1, pix_index=7 at N+2. DrawX=240 → sprite_on=0.
- Transparency and blank: rom_q=TRANSP_IDX → sprite_on=0, pix_index=0. blank=0 with an opaque pixel → sprite_on=0.
- Flip and scale: flip=1, scale_sh=1, DrawX=SpriteX+3, DrawY=SpriteY+5 → col=138, row=2, rom_addr=2*140+138=418.
- Looping animation: start with base=2, len=3, loop=1, hold=1; issue 8 frame_ticks → cur_frame sequence 2,2,3,3,4,4,2,2; busy=1 throughout; anim_done never asserts.
- One-shot with edge cases: start with base=6, len=3, loop=0, hold=0 → cur_frame 6,7,7 (saturated); anim_done pulses once, state DONE, busy=0. Then start+stop in the same cycle → PLAY. Then stop → IDLE, frame held.
- Reset mid-animation: in PLAY with step=2, assert reset for 1 cycle → cur_frame=0, busy=0, sprite_on=0 for the next 2 cycles.
